// File: rtl/weight_fetch_arbiter.sv
// Round-robin arbiter sharing one weight-memory read port between burst requesters.
// Bursts run to completion; returned words are steered to the owner, with a done pulse on the last word.
module weight_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 128,
  parameter int CNT_W   = 11,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base,
  input  logic [NUM_REQ*CNT_W-1:0]  req_count,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_W-1:0]         mem_rd_data,
  input  logic                      mem_rd_valid,
  output logic                      busy,
  output logic [ID_W-1:0]           owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    returned_q, returned_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  rspValid_q, rspValid_d;
  logic [NUM_REQ-1:0]  rspDone_q, rspDone_d;
  logic [DATA_W-1:0]   rspData_q, rspData_d;
  logic                memRdEn_q, memRdEn_d;
  logic [ADDR_W-1:0]   memRdAddr_q, memRdAddr_d;

  logic [ID_W-1:0]     winner;
  logic [NUM_REQ-1:0]  winnerHot;
  logic [NUM_REQ-1:0]  ownerHot;
  logic [ADDR_W-1:0]   winBase;
  logic [CNT_W-1:0]    winCount;

  // Scanning from the farthest slot down lets the nearest requester after ptr overwrite the rest.
  function automatic logic [ID_W-1:0] nextWinner(input logic [NUM_REQ-1:0] r,
                                                 input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] w;
    int idx;
    w = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (r[idx]) w = ID_W'(idx);
    end
    return w;
  endfunction

  assign winner    = nextWinner(req, rrPtr_q);
  assign winnerHot = NUM_REQ'(1) << winner;
  assign ownerHot  = NUM_REQ'(1) << owner_q;
  assign winBase   = req_base[int'(winner)*ADDR_W +: ADDR_W];
  assign winCount  = req_count[int'(winner)*CNT_W +: CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rrPtr_q     <= ID_W'(NUM_REQ-1);
      owner_q     <= '0;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      rspValid_q  <= '0;
      rspDone_q   <= '0;
      rspData_q   <= '0;
      memRdEn_q   <= 1'b0;
      memRdAddr_q <= '0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      rspValid_q  <= rspValid_d;
      rspDone_q   <= rspDone_d;
      rspData_q   <= rspData_d;
      memRdEn_q   <= memRdEn_d;
      memRdAddr_q <= memRdAddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    owner_d     = owner_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    returned_d  = returned_q;
    busy_d      = busy_q;
    grant_d     = '0;
    rspValid_d  = '0;
    rspDone_d   = '0;
    rspData_d   = rspData_q;
    memRdEn_d   = 1'b0;
    memRdAddr_d = memRdAddr_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d    = winner;
          base_d     = winBase;
          count_d    = winCount;
          issued_d   = '0;
          returned_d = '0;
          grant_d    = winnerHot;
          rrPtr_d    = winner;
          if (winCount != '0) begin
            busy_d  = 1'b1;
            state_d = ISSUE;
          end else begin
            rspDone_d = winnerHot;
          end
        end
      end
      // The extra ISSUE cycle at issued==count keeps the registered strobe confined to ISSUE.
      ISSUE: begin
        if (issued_q == count_q) begin
          state_d = DRAIN;
        end else begin
          memRdEn_d   = 1'b1;
          memRdAddr_d = base_q + ADDR_W'(issued_q);
          issued_d    = issued_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (state_q != IDLE && mem_rd_valid) begin
      rspData_d  = mem_rd_data;
      rspValid_d = ownerHot;
      returned_d = returned_q + CNT_W'(1);
      if (returned_q == count_q - CNT_W'(1)) begin
        rspDone_d = ownerHot;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    end
  end

  assign grant       = grant_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_done    = rspDone_q;
  assign rsp_data    = rspData_q;
  assign mem_rd_en   = memRdEn_q;
  assign mem_rd_addr = memRdAddr_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Scoreboard bench for weight_fetch_arbiter with a two-cycle-latency memory model.
// Expected grants, read addresses and returned words are queued when a request is posted.
module tb_weight_fetch_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 128;
  localparam int CNT_W   = 11;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_base;
  logic [NUM_REQ*CNT_W-1:0]  req_count;
  logic [NUM_REQ-1:0]        grant, rsp_valid, rsp_done;
  logic [DATA_W-1:0]         rsp_data, mem_rd_data;
  logic                      mem_rd_en, mem_rd_valid, busy;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic [ID_W-1:0]           owner;

  always #5 clk = ~clk;

  weight_fetch_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_count(req_count),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_done(rsp_done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .busy(busy), .owner(owner)
  );

  function automatic logic [DATA_W-1:0] dataOf(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {13'b0, a};
    return {32'hC0DE_0000 | w, ~w, w * 32'd7, 32'h1234_5678 ^ w};
  endfunction

  logic              p1Valid, p2Valid;
  logic [ADDR_W-1:0] p1Addr;
  logic [DATA_W-1:0] p2Data;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1Valid <= 1'b0;
      p2Valid <= 1'b0;
      p1Addr  <= '0;
      p2Data  <= '0;
    end else begin
      p1Valid <= mem_rd_en;
      p1Addr  <= mem_rd_addr;
      p2Valid <= p1Valid;
      p2Data  <= dataOf(p1Addr);
    end
  end
  assign mem_rd_valid = p2Valid;
  assign mem_rd_data  = p2Data;

  typedef struct {int id; bit zero;} grantExp_t;
  typedef struct {logic [ADDR_W-1:0] addr; bit first;} addrExp_t;
  typedef struct {logic [NUM_REQ-1:0] hot; int id; logic [DATA_W-1:0] data; bit last;} rspExp_t;

  grantExp_t grantQ[$];
  addrExp_t  addrQ[$];
  rspExp_t   rspQ[$];

  int  checks = 0;
  int  failures = 0;
  int  cycleCnt = 0;
  int  grantCycle = 0;
  bit  monEn = 1'b0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [ADDR_W-1:0] base, input int cnt);
    logic [ADDR_W-1:0] a;
    req_base[id*ADDR_W +: ADDR_W] = base;
    req_count[id*CNT_W +: CNT_W]  = CNT_W'(cnt);
    grantQ.push_back('{id, cnt == 0});
    for (int i = 0; i < cnt; i++) begin
      a = base + ADDR_W'(i);
      addrQ.push_back('{a, i == 0});
      rspQ.push_back('{NUM_REQ'(1) << id, id, dataOf(a), i == cnt - 1});
    end
  endtask

  task automatic waitGrant(input int id, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (grant[id]) begin
        seen = 1'b1;
        cyc  = cycleCnt;
      end
    end
    if (!seen) checkOutput($sformatf("grant%0d timeout", id), DATA_W'(grant), DATA_W'(1) << id);
  endtask

  task automatic waitDrain();
    int pending;
    pending = 1;
    for (int n = 0; n < 500 && pending != 0; n++) begin
      @(negedge clk);
      pending = grantQ.size() + addrQ.size() + rspQ.size() + int'(busy);
    end
    checkOutput("drain pending", DATA_W'(pending), '0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " grant"}, DATA_W'(grant), '0);
    checkOutput({tag, " rsp_valid"}, DATA_W'(rsp_valid), '0);
    checkOutput({tag, " rsp_done"}, DATA_W'(rsp_done), '0);
    checkOutput({tag, " rsp_data"}, rsp_data, '0);
    checkOutput({tag, " mem_rd_en"}, DATA_W'(mem_rd_en), '0);
    checkOutput({tag, " mem_rd_addr"}, DATA_W'(mem_rd_addr), '0);
    checkOutput({tag, " busy"}, DATA_W'(busy), '0);
    checkOutput({tag, " owner"}, DATA_W'(owner), '0);
  endtask

  // Output monitor: pops expectations as grants, reads and returned words appear.
  always @(negedge clk) begin
    grantExp_t g;
    addrExp_t  ea;
    rspExp_t   er;
    if (monEn) begin
      checkOutput("grant onehot", DATA_W'($onehot0(grant)), DATA_W'(1));
      checkOutput("rsp_valid onehot", DATA_W'($onehot0(rsp_valid)), DATA_W'(1));
      if (grant != '0) begin
        if (grantQ.size() == 0) begin
          checkOutput("unexpected grant", DATA_W'(grant), '0);
        end else begin
          g = grantQ.pop_front();
          grantCycle = cycleCnt;
          checkOutput("grant", DATA_W'(grant), DATA_W'(1) << g.id);
          checkOutput("grant busy", DATA_W'(busy), DATA_W'(!g.zero));
          checkOutput("grant done", DATA_W'(rsp_done), g.zero ? (DATA_W'(1) << g.id) : '0);
        end
      end
      if (mem_rd_en) begin
        if (addrQ.size() == 0) begin
          checkOutput("unexpected read", DATA_W'(mem_rd_addr), '0);
        end else begin
          ea = addrQ.pop_front();
          checkOutput("read addr", DATA_W'(mem_rd_addr), DATA_W'(ea.addr));
          if (ea.first) checkOutput("first read latency", DATA_W'(cycleCnt - grantCycle), DATA_W'(1));
        end
      end
      if (rsp_valid != '0) begin
        if (rspQ.size() == 0) begin
          checkOutput("unexpected rsp_valid", DATA_W'(rsp_valid), '0);
        end else begin
          er = rspQ.pop_front();
          checkOutput("rsp_valid", DATA_W'(rsp_valid), DATA_W'(er.hot));
          checkOutput("rsp_data", rsp_data, er.data);
          checkOutput("rsp_done", DATA_W'(rsp_done), er.last ? DATA_W'(er.hot) : '0);
          checkOutput("rsp busy", DATA_W'(busy), DATA_W'(!er.last));
          checkOutput("owner", DATA_W'(owner), DATA_W'(er.id));
        end
      end else if (rsp_done != '0 && grant == '0) begin
        checkOutput("stray done", DATA_W'(rsp_done), '0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c1, reads;
    rst = 1'b1;
    req = '0;
    req_base = '0;
    req_count = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    monEn = 1'b1;

    $display("[TB] round-robin with all requesters held");
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, ADDR_W'(32'h1000 + 32'h100 * i), 2);
    applyStimulus(0, ADDR_W'(32'h1000), 2);
    req = '1;
    waitGrant(0, c0);
    waitGrant(1, c0);
    waitGrant(2, c0);
    waitGrant(3, c0);
    waitGrant(0, c0);
    req = '0;
    waitDrain();

    $display("[TB] single burst");
    applyStimulus(0, ADDR_W'(32'h100), 4);
    req[0] = 1'b1;
    waitGrant(0, c0);
    req[0] = 1'b0;
    waitDrain();

    $display("[TB] zero-count burst followed by immediate grant");
    applyStimulus(2, ADDR_W'(32'h55), 0);
    applyStimulus(3, ADDR_W'(32'h77), 1);
    req[2] = 1'b1;
    req[3] = 1'b1;
    waitGrant(2, c0);
    req[2] = 1'b0;
    waitGrant(3, c1);
    req[3] = 1'b0;
    checkOutput("zero-count next grant gap", DATA_W'(c1 - c0), DATA_W'(1));
    waitDrain();

    $display("[TB] address wrap with request dropped after grant");
    applyStimulus(1, ADDR_W'(32'h7FFFE), 4);
    req[1] = 1'b1;
    waitGrant(1, c0);
    req[1] = 1'b0;
    waitDrain();

    $display("[TB] fairness with requester 0 re-requesting");
    applyStimulus(0, ADDR_W'(32'h200), 2);
    req[0] = 1'b1;
    waitGrant(0, c0);
    applyStimulus(3, ADDR_W'(32'h400), 2);
    applyStimulus(0, ADDR_W'(32'h300), 2);
    req[3] = 1'b1;
    waitGrant(3, c0);
    req[3] = 1'b0;
    waitGrant(0, c0);
    req[0] = 1'b0;
    waitDrain();

    $display("[TB] reset in the middle of a long burst");
    monEn = 1'b0;
    req_base[1*ADDR_W +: ADDR_W] = ADDR_W'(32'h500);
    req_count[1*CNT_W +: CNT_W]  = CNT_W'(64);
    req[1] = 1'b1;
    reads = 0;
    for (int n = 0; n < 300 && reads < 10; n++) begin
      @(negedge clk);
      if (mem_rd_en) reads++;
    end
    checkOutput("reads before reset", DATA_W'(reads), DATA_W'(10));
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    checkAllZero("mid-burst reset");
    grantQ.delete();
    addrQ.delete();
    rspQ.delete();
    applyStimulus(0, ADDR_W'(32'h600), 1);
    applyStimulus(1, ADDR_W'(32'h700), 1);
    req = 4'b0011;
    rst = 1'b0;
    monEn = 1'b1;
    waitGrant(0, c0);
    req[0] = 1'b0;
    waitGrant(1, c0);
    req[1] = 1'b0;
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
